// File: rtl/pll_pkg.sv
// Shared PLL definitions: sequencer FSM states, default timing constants and
// the PLL config index width common with the DRP stage.
package pll_pkg;

  // Config index width, shared with the PLL DRP stage.
  localparam int unsigned PllAw = 8;

  // Default sequencer timing, in CLK cycles.
  localparam int unsigned DefTow    = 20;
  localparam int unsigned DefUnlkTo = 1024;
  localparam int unsigned DefLockTo = 500000;
  localparam int unsigned DefSettle = 64;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitUnlk,
    StWaitLock,
    StSettle,
    StFin
  } pll_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser, asynchronously reset to 0.
module sync2 #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_cfg_seq.sv
// PLL reconfiguration sequencer: accepts a config index, strobes it into the
// PLL control stage, then follows lock loss / re-acquisition and reports DONE
// or a sticky timeout ERR.
// Optional feature: define PLL_CFG_SEQ_SWEEP_EN to add SWEEP / SWEEP_LAST,
// which auto-step PLL_ADDR after each successful sequence.
module pll_cfg_seq
  import pll_pkg::*;
#(
  parameter int unsigned AW      = PllAw,
  parameter int unsigned TOW     = DefTow,
  parameter int unsigned UNLK_TO = DefUnlkTo,
  parameter int unsigned LOCK_TO = DefLockTo,
  parameter int unsigned SETTLE  = DefSettle
) (
  input  logic          CLK,
  input  logic          RSTXO,
`ifdef PLL_CFG_SEQ_SWEEP_EN
  input  logic          SWEEP,
  input  logic [AW-1:0] SWEEP_LAST,
`endif
  input  logic          REQ,
  input  logic [AW-1:0] REQ_ADDR,
  input  logic          LOCK_IN,
  output logic          BUSY,
  output logic [AW-1:0] PLL_ADDR,
  output logic          PLL_CHG,
  output logic          DONE,
  output logic          ERR,
  output logic          LOCKED_S
);

  localparam logic [TOW-1:0] CntOne     = TOW'(1);
  localparam logic [TOW-1:0] UnlkLast   = TOW'(UNLK_TO - 1);
  localparam logic [TOW-1:0] LockLast   = TOW'(LOCK_TO - 1);
  localparam logic [TOW-1:0] SettleLast = TOW'(SETTLE - 1);

  pll_state_e    state_q, state_d;
  logic [TOW-1:0] cnt_q, cnt_d;
  logic [TOW-1:0] cnt_inc;
  logic [AW-1:0]  addr_q, addr_d;
  logic           err_q, err_d;
  logic           lock_s;

  sync2 #(
    .Width (1)
  ) u_lock_sync (
    .clk_i  (CLK),
    .rst_ni (RSTXO),
    .d_i    (LOCK_IN),
    .q_o    (lock_s)
  );

  // Counter saturates instead of wrapping.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CntOne;

`ifdef PLL_CFG_SEQ_SWEEP_EN
  localparam logic [AW-1:0] AddrOne = AW'(1);
  // Set by a successful FIN; consumed (or dropped) on the next IDLE cycle.
  logic arm_q, arm_d;
`endif

  // Next-state, counter, address and error logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    err_d   = err_q;
`ifdef PLL_CFG_SEQ_SWEEP_EN
    arm_d   = arm_q;
`endif
    unique case (state_q)
      StIdle: begin
`ifdef PLL_CFG_SEQ_SWEEP_EN
        arm_d = 1'b0;
`endif
        if (REQ) begin
          addr_d  = REQ_ADDR;
          err_d   = 1'b0;
          state_d = StIssue;
        end
`ifdef PLL_CFG_SEQ_SWEEP_EN
        else if (SWEEP && arm_q) begin
          addr_d  = (addr_q == SWEEP_LAST) ? '0 : addr_q + AddrOne;
          err_d   = 1'b0;
          state_d = StIssue;
        end
`endif
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWaitUnlk;
      end
      StWaitUnlk: begin
        // Timeout path covers a config that never drops lock.
        if (!lock_s || (cnt_q == UnlkLast)) begin
          cnt_d   = '0;
          state_d = StWaitLock;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StWaitLock: begin
        if (lock_s) begin
          cnt_d   = '0;
          state_d = StSettle;
        end else if (cnt_q == LockLast) begin
          err_d   = 1'b1;
          state_d = StFin;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StSettle: begin
        // Any drop restarts the full lock wait.
        if (!lock_s) begin
          cnt_d   = '0;
          state_d = StWaitLock;
        end else if (cnt_q == SettleLast) begin
          state_d = StFin;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StFin: begin
`ifdef PLL_CFG_SEQ_SWEEP_EN
        arm_d = !err_q;
`endif
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RSTXO) begin
    if (!RSTXO) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

`ifdef PLL_CFG_SEQ_SWEEP_EN
  // Sweep arm flag register.
  always_ff @(posedge CLK or negedge RSTXO) begin
    if (!RSTXO) begin
      arm_q <= 1'b0;
    end else begin
      arm_q <= arm_d;
    end
  end
`endif

  // Outputs decode directly from registered state, so reset clears them at once.
  always_comb begin
    BUSY     = (state_q != StIdle);
    PLL_CHG  = (state_q == StIssue);
    DONE     = (state_q == StFin) && !err_q;
    PLL_ADDR = addr_q;
    ERR      = err_q;
    LOCKED_S = lock_s;
  end

endmodule

// File: tb/tb_pll_cfg_seq.sv
// Directed bench for pll_cfg_seq; define PLL_CFG_SEQ_SWEEP_EN to add the sweep test.
module tb_pll_cfg_seq;

  localparam int unsigned AW      = 8;
  localparam int unsigned UNLK_TO = 1024;
  localparam int unsigned LOCK_TO = 200;
  localparam int unsigned SETTLE  = 64;

  logic          clk;
  logic          rstxo;
  logic          req;
  logic [AW-1:0] req_addr;
  logic          lock_in;
  logic          busy;
  logic [AW-1:0] pll_addr;
  logic          pll_chg;
  logic          done;
  logic          err;
  logic          locked_s;
`ifdef PLL_CFG_SEQ_SWEEP_EN
  logic          sweep;
  logic [AW-1:0] sweep_last;
`endif

  int passed = 0;
  int total  = 0;
  int chg_cnt  = 0;
  int done_cnt = 0;
  logic [AW-1:0] chg_addrs[$];

  pll_cfg_seq #(
    .AW      (AW),
    .TOW     (20),
    .UNLK_TO (UNLK_TO),
    .LOCK_TO (LOCK_TO),
    .SETTLE  (SETTLE)
  ) dut (
    .CLK        (clk),
    .RSTXO      (rstxo),
`ifdef PLL_CFG_SEQ_SWEEP_EN
    .SWEEP      (sweep),
    .SWEEP_LAST (sweep_last),
`endif
    .REQ        (req),
    .REQ_ADDR   (req_addr),
    .LOCK_IN    (lock_in),
    .BUSY       (busy),
    .PLL_ADDR   (pll_addr),
    .PLL_CHG    (pll_chg),
    .DONE       (done),
    .ERR        (err),
    .LOCKED_S   (locked_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters and strobe address log, sampled mid-cycle.
  always @(negedge clk) begin
    if (pll_chg === 1'b1) begin
      chg_cnt = chg_cnt + 1;
      chg_addrs.push_back(pll_addr);
    end
    if (done === 1'b1) done_cnt = done_cnt + 1;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    rstxo = 1'b0;
    req   = 1'b0;
    tick(1);
    rstxo = 1'b1;
    tick(3);
  endtask

  task automatic test_reset();
    rstxo = 1'b0;
    req = 1'b0;
    req_addr = 8'hA5;
    lock_in = 1'b1;
`ifdef PLL_CFG_SEQ_SWEEP_EN
    sweep = 1'b0;
    sweep_last = '0;
`endif
    tick(2);
    total++;
    if ({busy, pll_addr, pll_chg, done, err, locked_s} !== 13'h0)
      $display("FAIL reset_outputs: got %b required all zero",
               {busy, pll_addr, pll_chg, done, err, locked_s});
    else passed++;
    rstxo = 1'b1;
    tick(1);
    total++;
    if (locked_s !== 1'b0) $display("FAIL sync_lag1: got %b required 0", locked_s);
    else passed++;
    tick(1);
    total++;
    if (locked_s !== 1'b1) $display("FAIL sync_lag2: got %b required 1", locked_s);
    else passed++;
  endtask

  task automatic test_nominal();
    int c0, d0;
    c0 = chg_cnt;
    d0 = done_cnt;
    req = 1'b1;
    req_addr = 8'h05;
    tick(1);
    req = 1'b0;
    total++;
    if (busy !== 1'b1 || pll_addr !== 8'h05 || pll_chg !== 1'b1)
      $display("FAIL nom_accept: busy=%b addr=%h chg=%b required 1/05/1", busy, pll_addr, pll_chg);
    else passed++;
    tick(1);
    total++;
    if (pll_chg !== 1'b0) $display("FAIL nom_chg_one_cycle: got %b required 0", pll_chg);
    else passed++;
    tick(9);
    lock_in = 1'b0;
    tick(100);
    lock_in = 1'b1;
    tick(SETTLE + 2);
    total++;
    if (done !== 1'b0 || done_cnt != d0)
      $display("FAIL nom_done_early: done=%b pulses=%0d required 0/0", done, done_cnt - d0);
    else passed++;
    tick(1);
    total++;
    if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b1)
      $display("FAIL nom_done: done=%b err=%b busy=%b required 1/0/1", done, err, busy);
    else passed++;
    tick(1);
    total++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL nom_after: done=%b busy=%b required 0/0", done, busy);
    else passed++;
    total++;
    if (chg_cnt - c0 != 1 || done_cnt - d0 != 1 || pll_addr !== 8'h05)
      $display("FAIL nom_counts: chg=%0d done=%0d addr=%h required 1/1/05",
               chg_cnt - c0, done_cnt - d0, pll_addr);
    else passed++;
  endtask

  task automatic test_no_unlock();
    int d0;
    d0 = done_cnt;
    lock_in = 1'b1;
    req = 1'b1;
    req_addr = 8'h33;
    tick(1);
    req = 1'b0;
    tick(UNLK_TO + SETTLE + 1);
    total++;
    if (done !== 1'b0 || busy !== 1'b1 || done_cnt != d0)
      $display("FAIL nounlk_early: done=%b busy=%b required 0/1", done, busy);
    else passed++;
    tick(1);
    total++;
    if (done !== 1'b1 || err !== 1'b0)
      $display("FAIL nounlk_done: done=%b err=%b required 1/0", done, err);
    else passed++;
    tick(1);
    total++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL nounlk_idle: busy=%b done=%b required 0/0", busy, done);
    else passed++;
  endtask

  task automatic test_lock_timeout();
    int d0;
    d0 = done_cnt;
    lock_in = 1'b1;
    req = 1'b1;
    req_addr = 8'h44;
    tick(1);
    req = 1'b0;
    lock_in = 1'b0;
    tick(LOCK_TO + 2);
    total++;
    if (err !== 1'b0 || busy !== 1'b1)
      $display("FAIL to_early: err=%b busy=%b required 0/1", err, busy);
    else passed++;
    tick(1);
    total++;
    if (err !== 1'b1 || done !== 1'b0)
      $display("FAIL to_err: err=%b done=%b required 1/0", err, done);
    else passed++;
    tick(1);
    total++;
    if (busy !== 1'b0 || err !== 1'b1 || done_cnt != d0)
      $display("FAIL to_idle: busy=%b err=%b dones=%0d required 0/1/0", busy, err, done_cnt - d0);
    else passed++;
    lock_in = 1'b1;
    tick(3);
    total++;
    if (err !== 1'b1) $display("FAIL to_sticky: got %b required 1", err);
    else passed++;
    req = 1'b1;
    req_addr = 8'h07;
    tick(1);
    req = 1'b0;
    total++;
    if (err !== 1'b0 || pll_addr !== 8'h07)
      $display("FAIL to_clear: err=%b addr=%h required 0/07", err, pll_addr);
    else passed++;
    apply_reset();
  endtask

  task automatic test_settle_glitch();
    int d0;
    lock_in = 1'b1;
    apply_reset();
    d0 = done_cnt;
    req = 1'b1;
    req_addr = 8'h21;
    tick(1);
    req = 1'b0;
    tick(1);
    lock_in = 1'b0;
    tick(20);
    lock_in = 1'b1;
    tick(20);
    lock_in = 1'b0;
    tick(3);
    lock_in = 1'b1;
    tick(SETTLE + 2);
    total++;
    if (done !== 1'b0 || done_cnt != d0)
      $display("FAIL glitch_early: done=%b dones=%0d required 0/0", done, done_cnt - d0);
    else passed++;
    tick(1);
    total++;
    if (done !== 1'b1 || err !== 1'b0)
      $display("FAIL glitch_done: done=%b err=%b required 1/0", done, err);
    else passed++;
    tick(1);
  endtask

  task automatic test_busy_and_reset();
    int c0;
    lock_in = 1'b1;
    apply_reset();
    c0 = chg_cnt;
    req = 1'b1;
    req_addr = 8'h05;
    tick(1);
    lock_in = 1'b0;
    req_addr = 8'h09;
    tick(20);
    total++;
    if (chg_cnt - c0 != 1 || pll_addr !== 8'h05 || busy !== 1'b1)
      $display("FAIL busy_ignore: chg=%0d addr=%h busy=%b required 1/05/1",
               chg_cnt - c0, pll_addr, busy);
    else passed++;
    rstxo = 1'b0;
    tick(1);
    total++;
    if ({busy, pll_addr, pll_chg, done, err, locked_s} !== 13'h0)
      $display("FAIL midreset: got %b required all zero",
               {busy, pll_addr, pll_chg, done, err, locked_s});
    else passed++;
    req = 1'b0;
    lock_in = 1'b1;
    rstxo = 1'b1;
    tick(3);
  endtask

`ifdef PLL_CFG_SEQ_SWEEP_EN
  task automatic test_sweep();
    int c0, d0, budget;
    logic [AW-1:0] exp_addr [4];
    exp_addr[0] = 8'd1;
    exp_addr[1] = 8'd2;
    exp_addr[2] = 8'd0;
    exp_addr[3] = 8'd1;
    lock_in = 1'b1;
    apply_reset();
    c0 = chg_cnt;
    d0 = done_cnt;
    sweep = 1'b1;
    sweep_last = 8'd2;
    req = 1'b1;
    req_addr = 8'd1;
    tick(1);
    req = 1'b0;
    budget = 0;
    while (chg_cnt - c0 < 4 && budget < 10000) begin
      tick(1);
      budget++;
    end
    sweep = 1'b0;
    budget = 0;
    while (done_cnt - d0 < 4 && budget < 3000) begin
      tick(1);
      budget++;
    end
    tick(20);
    total++;
    if (chg_cnt - c0 != 4 || done_cnt - d0 != 4)
      $display("FAIL sweep_counts: chg=%0d done=%0d required 4/4", chg_cnt - c0, done_cnt - d0);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (c0 + i >= chg_addrs.size())
        $display("FAIL sweep_addr%0d: missing strobe required %h", i, exp_addr[i]);
      else if (chg_addrs[c0 + i] !== exp_addr[i])
        $display("FAIL sweep_addr%0d: got %h required %h", i, chg_addrs[c0 + i], exp_addr[i]);
      else passed++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_no_unlock();
    test_lock_timeout();
    test_settle_glitch();
    test_busy_and_reset();
`ifdef PLL_CFG_SEQ_SWEEP_EN
    test_sweep();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
